// File: rtl/seq_regfile_write_arbiter_if.sv
// seq_regfile_write_arbiter_if: writeback requesters, load issue, decode hazard and register-file write port bundle.
interface seq_regfile_write_arbiter_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 3
);
    localparam int NREG = 1 << ADDR_SIZE;
    logic                 i_sys_halt;
    logic                 i_a_valid;
    logic [ADDR_SIZE-1:0] i_a_dest;
    logic [DATA_SIZE-1:0] i_a_data;
    logic                 o_a_ready;
    logic                 i_b_valid;
    logic [ADDR_SIZE-1:0] i_b_dest;
    logic [DATA_SIZE-1:0] i_b_data;
    logic                 o_b_ready;
    logic                 i_issue_valid;
    logic [ADDR_SIZE-1:0] i_issue_dest;
    logic                 o_issue_ready;
    logic [ADDR_SIZE-1:0] i_source1;
    logic [ADDR_SIZE-1:0] i_source2;
    logic [1:0]           i_src_used;
    logic                 o_stall;
    logic                 o_register_file_write;
    logic [ADDR_SIZE-1:0] o_destination;
    logic [DATA_SIZE-1:0] o_result;
    logic [NREG-1:0]      o_pending;

    modport master (
        output i_sys_halt, i_a_valid, i_a_dest, i_a_data, i_b_valid, i_b_dest, i_b_data,
               i_issue_valid, i_issue_dest, i_source1, i_source2, i_src_used,
        input  o_a_ready, o_b_ready, o_issue_ready, o_stall, o_register_file_write,
               o_destination, o_result, o_pending
    );

    modport slave (
        input  i_sys_halt, i_a_valid, i_a_dest, i_a_data, i_b_valid, i_b_dest, i_b_data,
               i_issue_valid, i_issue_dest, i_source1, i_source2, i_src_used,
        output o_a_ready, o_b_ready, o_issue_ready, o_stall, o_register_file_write,
               o_destination, o_result, o_pending
    );
endinterface

// File: rtl/seq_regfile_write_arbiter.sv
// seq_regfile_write_arbiter: shares the register-file write port between ALU (A) and load (B) writebacks and scoreboards pending loads.
// Build option SEQ_RF_ARB_RR_EN: round-robin arbitration; when undefined, the load unit has fixed priority over the ALU.
module seq_regfile_write_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 3
) (
    input logic i_clk,
    input logic i_rst_n,
    seq_regfile_write_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_SIZE;

    logic                 grant_a, grant_b, issue_ready;
    logic                 wr_d, wr_q, wr_b_d, wr_b_q;
    logic [ADDR_SIZE-1:0] dest_d, dest_q;
    logic [DATA_SIZE-1:0] result_d, result_q;
    logic [NREG-1:0]      pending_d, pending_q;

`ifdef SEQ_RF_ARB_RR_EN
    logic favour_b_d, favour_b_q;

    // Round-robin grant: on contention follow the pointer, then hand priority to the other side.
    always_comb begin
        grant_b    = ~bus.i_sys_halt && bus.i_b_valid && (~bus.i_a_valid || favour_b_q);
        grant_a    = ~bus.i_sys_halt && bus.i_a_valid && ~grant_b;
        favour_b_d = grant_b ? 1'b0 : grant_a ? 1'b1 : favour_b_q;
    end

    // Arbitration pointer; reset favours the load unit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) favour_b_q <= 1'b1;
        else          favour_b_q <= favour_b_d;
    end
`else
    // Fixed priority: a load writeback always wins over the ALU.
    always_comb begin
        grant_b = ~bus.i_sys_halt && bus.i_b_valid;
        grant_a = ~bus.i_sys_halt && bus.i_a_valid && ~grant_b;
    end
`endif

    assign issue_ready = ~bus.i_sys_halt && ~pending_q[bus.i_issue_dest];

    // Capture the granted write for the next cycle; scoreboard clears on a committed load write and sets on an accepted issue.
    always_comb begin
        wr_d      = grant_a || grant_b;
        wr_b_d    = grant_b;
        dest_d    = grant_b ? bus.i_b_dest : grant_a ? bus.i_a_dest : dest_q;
        result_d  = grant_b ? bus.i_b_data : grant_a ? bus.i_a_data : result_q;
        pending_d = pending_q;
        if (wr_q && wr_b_q) pending_d[dest_q] = 1'b0;
        if (bus.i_issue_valid && issue_ready) pending_d[bus.i_issue_dest] = 1'b1;
    end

    // Registered write port and scoreboard; reset drops any in-flight write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q      <= 1'b0;
            wr_b_q    <= 1'b0;
            dest_q    <= '0;
            result_q  <= '0;
            pending_q <= '0;
        end else begin
            wr_q      <= wr_d;
            wr_b_q    <= wr_b_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            pending_q <= pending_d;
        end
    end

    assign bus.o_a_ready             = grant_a;
    assign bus.o_b_ready             = grant_b;
    assign bus.o_issue_ready         = issue_ready;
    assign bus.o_stall               = (bus.i_src_used[0] && pending_q[bus.i_source1]) ||
                                       (bus.i_src_used[1] && pending_q[bus.i_source2]);
    assign bus.o_register_file_write = wr_q;
    assign bus.o_destination         = dest_q;
    assign bus.o_result              = result_q;
    assign bus.o_pending             = pending_q;
endmodule

// File: tb/tb_seq_regfile_write_arbiter.sv
// tb_seq_regfile_write_arbiter: scoreboard bench for the register-file write arbiter.
module tb_seq_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_regfile_write_arbiter_if #(.DATA_SIZE(32), .ADDR_SIZE(3)) bus ();
    seq_regfile_write_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(3)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [2:0]  d;
        logic [31:0] v;
        logic        b;
    } wr_t;

    wr_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_pend = '0;
    logic       m_fav_b = 1'b1;
    logic [3:0] glog = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.i_sys_halt    = 1'b0;
        bus.i_a_valid     = 1'b0;
        bus.i_b_valid     = 1'b0;
        bus.i_issue_valid = 1'b0;
        bus.i_src_used    = 2'b00;
    endtask

    // One cycle: check last cycle's write and the combinational outputs, then advance the model at the edge.
    task automatic step();
        wr_t  e;
        logic clr, ga, gb, ir, st;
        clr = 1'b0;
        e   = '{d: 3'd0, v: 32'd0, b: 1'b0};
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_en", 64'(bus.o_register_file_write), 64'd1);
            chk("wr_dest", 64'(bus.o_destination), 64'(e.d));
            chk("wr_data", 64'(bus.o_result), 64'(e.v));
            clr = e.b;
        end else begin
            chk("wr_idle", 64'(bus.o_register_file_write), 64'd0);
        end
        chk("pending", 64'(bus.o_pending), 64'(m_pend));
`ifdef SEQ_RF_ARB_RR_EN
        gb = !bus.i_sys_halt && bus.i_b_valid && (!bus.i_a_valid || m_fav_b);
`else
        gb = !bus.i_sys_halt && bus.i_b_valid;
`endif
        ga = !bus.i_sys_halt && bus.i_a_valid && !gb;
        ir = !bus.i_sys_halt && !m_pend[bus.i_issue_dest];
        st = (bus.i_src_used[0] && m_pend[bus.i_source1]) || (bus.i_src_used[1] && m_pend[bus.i_source2]);
        chk("a_ready", 64'(bus.o_a_ready), 64'(ga));
        chk("b_ready", 64'(bus.o_b_ready), 64'(gb));
        chk("issue_ready", 64'(bus.o_issue_ready), 64'(ir));
        chk("stall", 64'(bus.o_stall), 64'(st));
        if (gb) exp_q.push_back('{d: bus.i_b_dest, v: bus.i_b_data, b: 1'b1});
        else if (ga) exp_q.push_back('{d: bus.i_a_dest, v: bus.i_a_data, b: 1'b0});
        m_fav_b = gb ? 1'b0 : ga ? 1'b1 : m_fav_b;
        glog = {glog[2:0], gb};
        if (clr) m_pend[e.d] = 1'b0;
        if (bus.i_issue_valid && ir) m_pend[bus.i_issue_dest] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.i_a_dest = '0; bus.i_a_data = '0;
        bus.i_b_dest = '0; bus.i_b_data = '0;
        bus.i_issue_dest = '0; bus.i_source1 = '0; bus.i_source2 = '0;
        #2;
        chk("rst_wr", 64'(bus.o_register_file_write), 64'd0);
        chk("rst_dest", 64'(bus.o_destination), 64'd0);
        chk("rst_result", 64'(bus.o_result), 64'd0);
        chk("rst_pending", 64'(bus.o_pending), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both requesters hold valid for four cycles.
        bus.i_a_valid = 1'b1; bus.i_a_dest = 3'd1; bus.i_a_data = 32'hAAAA_0001;
        bus.i_b_valid = 1'b1; bus.i_b_dest = 3'd2; bus.i_b_data = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) step();
`ifdef SEQ_RF_ARB_RR_EN
        chk("contention", 64'(glog), 64'(4'b1010));
`else
        chk("contention", 64'(glog), 64'(4'b1111));
`endif
        bus.i_b_valid = 1'b0;
        step();
        idle();
        step();

        // Single ALU write, then idle.
        bus.i_a_valid = 1'b1; bus.i_a_dest = 3'd3; bus.i_a_data = 32'hDEAD_BEEF;
        step();
        idle();
        step();
        step();

        // Load hazard on R5.
        bus.i_issue_valid = 1'b1; bus.i_issue_dest = 3'd5;
        step();
        bus.i_source1 = 3'd5; bus.i_src_used = 2'b01;
        step();
        bus.i_issue_valid = 1'b0;
        bus.i_b_valid = 1'b1; bus.i_b_dest = 3'd5; bus.i_b_data = 32'h0000_1234;
        step();
        bus.i_b_valid = 1'b0;
        step();
        step();
        chk("stall_drop", 64'(bus.o_stall), 64'd0);

        // Unused source does not stall.
        bus.i_src_used = 2'b00; bus.i_source1 = 3'd0;
        bus.i_issue_valid = 1'b1; bus.i_issue_dest = 3'd2;
        step();
        bus.i_issue_valid = 1'b0; bus.i_source2 = 3'd2; bus.i_src_used = 2'b01;
        step();
        bus.i_src_used = 2'b10;
        step();
        bus.i_src_used = 2'b00;
        bus.i_b_valid = 1'b1; bus.i_b_dest = 3'd2; bus.i_b_data = 32'h0000_00B2;
        step();
        idle();
        step();
        step();

        // Halt: in-flight write completes, no grants or issues while halted.
        bus.i_a_valid = 1'b1; bus.i_a_dest = 3'd6; bus.i_a_data = 32'h0000_0066;
        step();
        bus.i_sys_halt = 1'b1; bus.i_a_data = 32'h0000_0077;
        bus.i_issue_valid = 1'b1; bus.i_issue_dest = 3'd7;
        step();
        step();
        bus.i_sys_halt = 1'b0; bus.i_issue_valid = 1'b0;
        step();
        idle();
        step();
        step();

        // Async reset mid-write with R4 pending.
        bus.i_issue_valid = 1'b1; bus.i_issue_dest = 3'd4;
        step();
        bus.i_issue_valid = 1'b0;
        bus.i_a_valid = 1'b1; bus.i_a_dest = 3'd7; bus.i_a_data = 32'h5555_AAAA;
        step();
        idle();
        chk("pre_rst_pending", 64'(bus.o_pending), 64'h10);
        chk("pre_rst_wr", 64'(bus.o_register_file_write), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 64'(bus.o_register_file_write), 64'd0);
        chk("mid_rst_dest", 64'(bus.o_destination), 64'd0);
        chk("mid_rst_result", 64'(bus.o_result), 64'd0);
        chk("mid_rst_pending", 64'(bus.o_pending), 64'd0);
        exp_q.delete();
        m_pend = '0;
        m_fav_b = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();
        bus.i_a_valid = 1'b1; bus.i_a_dest = 3'd0; bus.i_a_data = 32'h0000_00A0;
        step();
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_regfile_write_arbiter.md
Name: seq_regfile_write_arbiter

Overview:
- Sequences the single write port of the core's 8-entry register file (R0-R7, 3-bit address).
- Shares that port between two writeback requesters: A = ALU/execute, B = load unit.
- Keeps a pending-load scoreboard and raises a read-hazard stall toward decode.
- Sits between the execute/load stages and the register file; its outputs drive the register file's write-enable, destination and result inputs directly.

Parameters:
DATA_SIZE, 32, width of writeback data
ADDR_SIZE, 3, register address width (8 registers)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_sys_halt  in  1  blocks new grants and new issues
i_a_valid  in  1  ALU writeback request
i_a_dest  in  ADDR_SIZE  ALU destination register
i_a_data  in  DATA_SIZE  ALU result
o_a_ready  out  1  ALU request accepted this cycle
i_b_valid  in  1  load writeback request
i_b_dest  in  ADDR_SIZE  load destination register
i_b_data  in  DATA_SIZE  load data
o_b_ready  out  1  load request accepted this cycle
i_issue_valid  in  1  load issued; mark destination pending
i_issue_dest  in  ADDR_SIZE  destination of the issued load
o_issue_ready  out  1  issue accepted (destination not pending, not halted)
i_source1  in  ADDR_SIZE  decode read address 1
i_source2  in  ADDR_SIZE  decode read address 2
i_src_used  in  2  bit0/bit1 = source1/source2 actually read
o_stall  out  1  read hazard on a pending register
o_register_file_write  out  1  register file write enable
o_destination  out  ADDR_SIZE  register file write address
o_result  out  DATA_SIZE  register file write data
o_pending  out  8  scoreboard bits, one per register

Behaviour:
- Reset (async, i_rst_n=0): o_register_file_write=0, o_destination=0, o_result=0, o_pending=0, RR pointer favours B. Reset asserted mid-operation discards any in-flight write and clears all pending bits immediately.
- Handshake: a transfer occurs when valid && ready in the same cycle. A requester holds valid/dest/data stable until accepted. Ready outputs are combinational grants. At most one grant per cycle. No grant while i_sys_halt=1.
- Write timing, 1-cycle latency: grant in cycle N gives o_register_file_write=1 in cycle N+1 with the granted dest/data. The register file commits at the end of N+1. With no grant in N, o_register_file_write=0 in N+1; o_destination/o_result hold their last values.
- Back-to-back grants are allowed every cycle; write throughput is 1 per cycle.
- Scoreboard set: i_issue_valid && o_issue_ready sets pending[i_issue_dest] at the clock edge.
- o_issue_ready = ~i_sys_halt && ~pending[i_issue_dest]. WAW on a pending load destination stalls.
- Scoreboard clear: pending[d] clears on the edge that commits a B write to d, i.e. end of cycle N+1 for a B grant in cycle N. An A write never clears pending.
- Simultaneous set and clear on the same register cannot occur: issue_ready is 0 while that bit is set.
- o_stall = (i_src_used[0] && pending[i_source1]) || (i_src_used[1] && pending[i_source2]). Combinational.
  - Stall stays high through cycle N+1 and drops in N+2, when the async register file read returns the new value.
- Halt: in-flight registered write still completes; pending bits still clear; no new grants or issues.
- All 8 registers, including R0, are writable and scoreboarded.

Optional Feature:
- Macro SEQ_RF_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both A and B are valid, grant the requester the pointer favours; after any grant the pointer favours the other requester.
  - A lone valid requester is always granted.
- Undefined: fixed priority, B (load) over A. The pointer logic is absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset check: pulse i_rst_n low mid-write with pending=8'h10 -> all outputs 0 and o_pending=0 immediately, without waiting for a clock edge.
- Single ALU write: i_a_valid=1, dest=3, data=32'hDEAD_BEEF in cycle N -> o_a_ready=1 in N; in N+1 o_register_file_write=1, o_destination=3, o_result=32'hDEAD_BEEF; in N+2 write=0.
- Load hazard:
  - Issue load to R5 -> o_pending[5]=1, o_issue_ready=0 for a second issue to R5.
  - source1=5 with i_src_used=2'b01 -> o_stall=1.
  - B writes R5=32'h1234 granted in N -> stall still 1 in N+1, 0 in N+2, pending[5]=0.
- Contention: A and B both valid for 4 cycles, both holding valid after acceptance.
  - With SEQ_RF_ARB_RR_EN: grants B,A,B,A.
  - Without: B,B,B,B while B stays valid, A granted only when B is idle.
- Halt: i_sys_halt=1 with A valid and a grant made the previous cycle -> previous write still appears, o_a_ready=0, o_issue_ready=0, no further writes until halt drops.
- Unused source: pending[2]=1, source2=2, i_src_used=2'b01 -> o_stall=0.
